// File: rtl/accum_cpu_core.sv
// accum_cpu_core
//   Accumulator execution core with a bank of NUM_ACC selectable accumulators,
//   an 8-entry ALU opcode set, carry/zero flags, optional saturating ADD/SUB,
//   and valid/ready handshakes on the instruction input and the store output.
//
// Ports
//   clock, reset         rising-edge clock; asynchronous active-low reset
//   instr_valid/ready    instruction handshake (opcode, reg_sel, Data_bus_in)
//   Data_bus_out         store data, held stable while store_valid is high
//   store_valid/ready    store handshake
//   out_acc              value of the most recently targeted accumulator
//   carry, zero          flags from the last non-STORE instruction
module accum_cpu_core #(
    parameter int WIDTH    = 8,
    parameter int NUM_ACC  = 4,
    parameter int SATURATE = 0,
    localparam int SEL_W   = $clog2(NUM_ACC)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       opcode,
    input  logic [SEL_W-1:0] reg_sel,
    input  logic [WIDTH-1:0] Data_bus_in,
    output logic [WIDTH-1:0] Data_bus_out,
    output logic             store_valid,
    input  logic             store_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_STORE = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110,
        OP_CLR   = 3'b111
    } opcode_e;

    typedef enum logic {
        S_IDLE       = 1'b0,
        S_WAIT_STORE = 1'b1
    } state_e;

    state_e                          state_q, state_d;
    logic [NUM_ACC-1:0][WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]                out_acc_q, out_acc_d;
    logic [WIDTH-1:0]                dout_q, dout_d;
    logic                            carry_q, carry_d;
    logic                            zero_q, zero_d;

    opcode_e          op;
    logic [WIDTH-1:0] cur;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             wr;

    assign op   = opcode_e'(opcode);
    assign cur  = acc_q[reg_sel];
    assign sum  = {1'b0, cur} + {1'b0, Data_bus_in};
    // Top bit of the extended difference is the borrow (operand > acc).
    assign diff = {1'b0, cur} - {1'b0, Data_bus_in};

    assign instr_ready  = (state_q == S_IDLE);
    assign store_valid  = (state_q == S_WAIT_STORE);
    assign Data_bus_out = dout_q;
    assign out_acc      = out_acc_q;
    assign carry        = carry_q;
    assign zero         = zero_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        out_acc_d = out_acc_q;
        dout_d    = dout_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        res       = '0;
        res_c     = 1'b0;
        wr        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    case (op)
                        OP_ADD: begin
                            res_c = sum[WIDTH];
                            res   = (SATURATE != 0 && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
                            wr    = 1'b1;
                        end
                        OP_SUB: begin
                            res_c = diff[WIDTH];
                            res   = (SATURATE != 0 && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
                            wr    = 1'b1;
                        end
                        OP_LOAD: begin res = Data_bus_in;       wr = 1'b1; end
                        OP_AND:  begin res = cur & Data_bus_in; wr = 1'b1; end
                        OP_OR:   begin res = cur | Data_bus_in; wr = 1'b1; end
                        OP_XOR:  begin res = cur ^ Data_bus_in; wr = 1'b1; end
                        OP_CLR:  begin res = '0;                wr = 1'b1; end
                        OP_STORE: begin
                            // Flags and accumulators untouched; only the
                            // observed accumulator and store data move.
                            dout_d    = cur;
                            out_acc_d = cur;
                            state_d   = S_WAIT_STORE;
                        end
                    endcase
                    if (wr) begin
                        acc_d[reg_sel] = res;
                        out_acc_d      = res;
                        carry_d        = res_c;
                        zero_d         = (res == '0);
                    end
                end
            end
            S_WAIT_STORE: begin
                if (store_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            out_acc_q <= '0;
            dout_q    <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            out_acc_q <= out_acc_d;
            dout_q    <= dout_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: tb/tb_accum_cpu_core.sv
// Bench for accum_cpu_core: one wrapping (SATURATE=0) and one saturating
// (SATURATE=1) instance share the same stimulus. Expected results come from a
// small behavioural model, pushed to a scoreboard queue when an instruction is
// driven and popped after the acceptance edge.
module tb_accum_cpu_core;

    localparam logic [2:0] ADD = 3'b000, LOAD = 3'b001, STORE = 3'b010, SUB = 3'b011;
    localparam logic [2:0] AND_ = 3'b100, OR_ = 3'b101, XOR_ = 3'b110, CLR = 3'b111;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [2:0] opcode = '0;
    logic [1:0] reg_sel = '0;
    logic [7:0] Data_bus_in = '0;
    logic       store_ready = 1'b0;

    logic       instr_ready_o [2];
    logic [7:0] dbo_o [2];
    logic       store_valid_o [2];
    logic [7:0] out_acc_o [2];
    logic       carry_o [2];
    logic       zero_o [2];

    always #5 clock = ~clock;

    accum_cpu_core #(.WIDTH(8), .NUM_ACC(4), .SATURATE(0)) u_wrap (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready_o[0]),
        .opcode(opcode), .reg_sel(reg_sel), .Data_bus_in(Data_bus_in),
        .Data_bus_out(dbo_o[0]), .store_valid(store_valid_o[0]), .store_ready(store_ready),
        .out_acc(out_acc_o[0]), .carry(carry_o[0]), .zero(zero_o[0])
    );

    accum_cpu_core #(.WIDTH(8), .NUM_ACC(4), .SATURATE(1)) u_sat (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready_o[1]),
        .opcode(opcode), .reg_sel(reg_sel), .Data_bus_in(Data_bus_in),
        .Data_bus_out(dbo_o[1]), .store_valid(store_valid_o[1]), .store_ready(store_ready),
        .out_acc(out_acc_o[1]), .carry(carry_o[1]), .zero(zero_o[1])
    );

    typedef struct {
        int         v;
        logic [7:0] acc;
        logic       c;
        logic       z;
    } exp_t;

    typedef struct {
        int         v;
        logic [7:0] data;
    } st_t;

    exp_t exp_q[$];
    st_t  st_q[$];

    int checks = 0;
    int failures = 0;

    // Behavioural model state, one copy per instance (index 1 = saturating).
    logic [7:0] m_acc [2][4];
    logic [7:0] m_out [2];
    logic       m_c [2];
    logic       m_z [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            for (int r = 0; r < 4; r++) m_acc[v][r] = 8'h00;
            m_out[v] = 8'h00;
            m_c[v]   = 1'b0;
            m_z[v]   = 1'b0;
        end
    endtask

    task automatic model(input int v, input logic [2:0] op, input int sel, input logic [7:0] d);
        int a, s, r;
        logic c;
        a = int'(m_acc[v][sel]);
        c = 1'b0;
        r = 0;
        case (op)
            ADD: begin
                s = a + int'(d);
                c = (s > 255);
                r = (c && v == 1) ? 255 : (s % 256);
            end
            SUB: begin
                c = (int'(d) > a);
                r = c ? ((v == 1) ? 0 : a - int'(d) + 256) : a - int'(d);
            end
            LOAD:  r = int'(d);
            AND_:  r = int'(m_acc[v][sel] & d);
            OR_:   r = int'(m_acc[v][sel] | d);
            XOR_:  r = int'(m_acc[v][sel] ^ d);
            default: r = 0;
        endcase
        if (op == STORE) begin
            m_out[v] = m_acc[v][sel];
            st_q.push_back('{v, m_acc[v][sel]});
        end else begin
            m_acc[v][sel] = 8'(r);
            m_out[v]      = 8'(r);
            m_c[v]        = c;
            m_z[v]        = (r == 0);
        end
    endtask

    // Drive one instruction (core assumed idle), let it be accepted, then
    // drain the scoreboard against both instances.
    task automatic issue(input logic [2:0] op, input int sel, input logic [7:0] d, input string tag);
        exp_t e;
        st_t  s;
        opcode      = op;
        reg_sel     = 2'(sel);
        Data_bus_in = d;
        instr_valid = 1'b1;
        for (int v = 0; v < 2; v++) begin
            model(v, op, sel, d);
            exp_q.push_back('{v, m_out[v], m_c[v], m_z[v]});
        end
        @(posedge clock); #1;
        instr_valid = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("%s/acc%0d", tag, e.v), 32'(out_acc_o[e.v]), 32'(e.acc));
            chk($sformatf("%s/carry%0d", tag, e.v), 32'(carry_o[e.v]), 32'(e.c));
            chk($sformatf("%s/zero%0d", tag, e.v), 32'(zero_o[e.v]), 32'(e.z));
        end
        while (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk($sformatf("%s/svalid%0d", tag, s.v), 32'(store_valid_o[s.v]), 32'd1);
            chk($sformatf("%s/irdy%0d", tag, s.v), 32'(instr_ready_o[s.v]), 32'd0);
            chk($sformatf("%s/dout%0d", tag, s.v), 32'(dbo_o[s.v]), 32'(s.data));
        end
    endtask

    task automatic finish_store(input string tag);
        store_ready = 1'b1;
        @(posedge clock); #1;
        store_ready = 1'b0;
        for (int v = 0; v < 2; v++) begin
            chk($sformatf("%s/svalid%0d", tag, v), 32'(store_valid_o[v]), 32'd0);
            chk($sformatf("%s/irdy%0d", tag, v), 32'(instr_ready_o[v]), 32'd1);
        end
    endtask

    initial begin
        model_reset();

        // 1. reset pulse, then a simple LOAD/ADD
        #2 reset = 1'b0;
        #6;
        for (int v = 0; v < 2; v++) begin
            chk($sformatf("rst/acc%0d", v), 32'(out_acc_o[v]), 32'h00);
            chk($sformatf("rst/carry%0d", v), 32'(carry_o[v]), 32'd0);
            chk($sformatf("rst/zero%0d", v), 32'(zero_o[v]), 32'd0);
            chk($sformatf("rst/svalid%0d", v), 32'(store_valid_o[v]), 32'd0);
            chk($sformatf("rst/irdy%0d", v), 32'(instr_ready_o[v]), 32'd1);
        end
        #4 reset = 1'b1;
        issue(LOAD, 0, 8'h0A, "t1_load");
        issue(ADD,  0, 8'h0A, "t1_add");
        chk("t1_const", 32'(out_acc_o[0]), 32'h14);

        // 2. overflow: wrap vs saturate
        issue(LOAD, 1, 8'hF0, "t2_load");
        issue(ADD,  1, 8'h20, "t2_add");
        chk("t2_wrap", 32'(out_acc_o[0]), 32'h10);
        chk("t2_sat",  32'(out_acc_o[1]), 32'hFF);

        // 3. subtract to zero, then borrow
        issue(LOAD, 2, 8'h0F, "t3_load");
        issue(SUB,  2, 8'h0F, "t3_sub0");
        chk("t3_zero", 32'(zero_o[0]), 32'd1);
        issue(SUB,  2, 8'h01, "t3_borrow");
        chk("t3_wrap", 32'(out_acc_o[0]), 32'hFF);
        chk("t3_sat",  32'(out_acc_o[1]), 32'h00);

        // 4. stalled store with an ADD waiting on the input
        issue(LOAD,  3, 8'h0F, "t4_load");
        issue(STORE, 3, 8'h00, "t4_store");
        opcode = ADD; reg_sel = 2'd3; Data_bus_in = 8'h01; instr_valid = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            for (int v = 0; v < 2; v++) begin
                chk($sformatf("t4_stall/svalid%0d", v), 32'(store_valid_o[v]), 32'd1);
                chk($sformatf("t4_stall/irdy%0d", v), 32'(instr_ready_o[v]), 32'd0);
                chk($sformatf("t4_stall/dout%0d", v), 32'(dbo_o[v]), 32'h0F);
                chk($sformatf("t4_stall/acc%0d", v), 32'(out_acc_o[v]), 32'h0F);
            end
        end
        finish_store("t4_done");
        chk("t4_notyet", 32'(out_acc_o[0]), 32'h0F);
        issue(ADD, 3, 8'h01, "t4_add");
        chk("t4_const", 32'(out_acc_o[1]), 32'h10);

        // 5. register independence and logic ops
        issue(LOAD, 0, 8'h55, "t5_load0");
        issue(LOAD, 1, 8'hAA, "t5_load1");
        issue(XOR_, 0, 8'hFF, "t5_xor");
        chk("t5_xor_const", 32'(out_acc_o[0]), 32'hAA);
        issue(STORE, 1, 8'h00, "t5_store");
        finish_store("t5_done");
        issue(AND_, 2, 8'hF0, "t5_and");
        issue(OR_,  2, 8'h0C, "t5_or");
        issue(CLR,  1, 8'h77, "t5_clr");
        chk("t5_clr_zero", 32'(zero_o[0]), 32'd1);
        issue(STORE, 0, 8'h00, "t5_store0");
        finish_store("t5_done0");

        // 6. asynchronous reset while a store is pending
        issue(STORE, 3, 8'h00, "t6_store");
        #2 reset = 1'b0;
        #1;
        model_reset();
        for (int v = 0; v < 2; v++) begin
            chk($sformatf("t6_rst/svalid%0d", v), 32'(store_valid_o[v]), 32'd0);
            chk($sformatf("t6_rst/acc%0d", v), 32'(out_acc_o[v]), 32'h00);
            chk($sformatf("t6_rst/irdy%0d", v), 32'(instr_ready_o[v]), 32'd1);
        end
        #10 reset = 1'b1;
        issue(STORE, 0, 8'h00, "t6_store0");
        chk("t6_dout_const", 32'(dbo_o[0]), 32'h00);
        finish_store("t6_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
